// File: rtl/sop_pkg.sv
// sop_pkg: shared widths and leading-one detect for the sum-of-products datapath
package sop_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  localparam int Y_W = 32;
  localparam int FRAC_W = 7;
  function automatic logic [2:0] lod8(input logic [OP_W-1:0] v);
    lod8 = '0;
    for (int i = 0; i < OP_W; i++) if (v[i]) lod8 = i[2:0];
  endfunction
endpackage

// File: rtl/approx_sop_core_if.sv
// approx_sop_core_if: operand/result bundle for the sum-of-products core
interface approx_sop_core_if;
  import sop_pkg::*;
  logic in_valid;
  logic signed [OP_W-1:0] a, b, c, d, e, f;
  logic out_valid;
  logic signed [Y_W-1:0] y;
  modport master(output in_valid, a, b, c, d, e, f, input out_valid, y);
  modport slave(input in_valid, a, b, c, d, e, f, output out_valid, y);
endinterface

// File: rtl/mitchell_mul.sv
// mitchell_mul: signed 8x8 product, Mitchell logarithmic approximation or exact
module mitchell_mul import sop_pkg::*; #(
  parameter bit APPROX = 1'b1
) (
  input  logic signed [OP_W-1:0]   p,
  input  logic signed [OP_W-1:0]   q,
  output logic signed [PROD_W-1:0] r
);
  if (APPROX) begin : g_mit
    logic [OP_W-1:0] mp, mq;
    logic [2:0] kp, kq;
    logic [FRAC_W-1:0] fp, fq;
    logic [7:0] t;
    logic [3:0] kk;
    logic [14:0] lo, hi, pm;
    always_comb begin
      mp = p[OP_W-1] ? OP_W'(-p) : OP_W'(p);
      mq = q[OP_W-1] ? OP_W'(-q) : OP_W'(q);
      kp = lod8(mp);
      kq = lod8(mq);
      // strip the leading one and left-align the remainder as a Q0.7 fraction
      fp = FRAC_W'((mp ^ (8'd1 << kp)) << (3'd7 - kp));
      fq = FRAC_W'((mq ^ (8'd1 << kq)) << (3'd7 - kq));
      t = {1'b0, fp} + {1'b0, fq};
      kk = {1'b0, kp} + {1'b0, kq};
      lo = 15'((24'(9'd128 + {1'b0, t}) << kk) >> 7);
      hi = 15'((24'(t) << (kk + 4'd1)) >> 7);
      pm = (mp == '0 || mq == '0) ? '0 : (t[7] ? hi : lo);
      r = (p[OP_W-1] ^ q[OP_W-1]) ? -PROD_W'(pm) : PROD_W'(pm);
    end
  end else begin : g_exact
    assign r = PROD_W'(p) * PROD_W'(q);
  end
endmodule

// File: rtl/approx_sop_core.sv
// approx_sop_core: registered y = a*b + c*d + e*f with selectable approximate products
module approx_sop_core import sop_pkg::*; #(
  parameter bit APPROX = 1'b1
) (
  input logic clk,
  input logic rst,
  approx_sop_core_if.slave bus
);
  logic signed [PROD_W-1:0] r0, r1, r2;
  logic signed [Y_W-1:0] sum;
  mitchell_mul #(.APPROX(APPROX)) u_m0 (.p(bus.a), .q(bus.b), .r(r0));
  mitchell_mul #(.APPROX(APPROX)) u_m1 (.p(bus.c), .q(bus.d), .r(r1));
  mitchell_mul #(.APPROX(APPROX)) u_m2 (.p(bus.e), .q(bus.f), .r(r2));
  always_comb sum = Y_W'(r0) + Y_W'(r1) + Y_W'(r2);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.y <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.y <= sum;
    end
  end
endmodule

// File: tb/tb_approx_sop_core.sv
// tb_approx_sop_core: directed and random checks of approximate and exact instances
module tb_approx_sop_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  approx_sop_core_if ia();
  approx_sop_core_if ie();
  approx_sop_core #(.APPROX(1'b1)) ua (.clk(clk), .rst(rst), .bus(ia.slave));
  approx_sop_core #(.APPROX(1'b0)) ue (.clk(clk), .rst(rst), .bus(ie.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic set_ops(input logic v, input int a, b, c, d, e, f);
    ia.in_valid = v; ie.in_valid = v;
    ia.a = 8'(a); ia.b = 8'(b); ia.c = 8'(c); ia.d = 8'(d); ia.e = 8'(e); ia.f = 8'(f);
    ie.a = 8'(a); ie.b = 8'(b); ie.c = 8'(c); ie.d = 8'(d); ie.e = 8'(e); ie.f = 8'(f);
  endtask

  task automatic drive(input logic v, input int a, b, c, d, e, f);
    @(negedge clk);
    set_ops(v, a, b, c, d, e, f);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_y(input string tag, input int ya, input int ye, input logic ov);
    chk({tag, "_approx_y"}, ia.y, ya);
    chk({tag, "_exact_y"}, ie.y, ye);
    chk({tag, "_approx_ov"}, 32'(ia.out_valid), 32'(ov));
    chk({tag, "_exact_ov"}, 32'(ie.out_valid), 32'(ov));
  endtask

  function automatic int mitch(input int p, input int q);
    int mp, mq, kp, kq, fp, fq, t, k, pr;
    mp = (p < 0) ? -p : p;
    mq = (q < 0) ? -q : q;
    if (mp == 0 || mq == 0) return 0;
    kp = 0;
    while ((2 ** (kp + 1)) <= mp) kp++;
    kq = 0;
    while ((2 ** (kq + 1)) <= mq) kq++;
    fp = (mp - 2 ** kp) * 2 ** (7 - kp);
    fq = (mq - 2 ** kq) * 2 ** (7 - kq);
    t = fp + fq;
    k = kp + kq;
    pr = (t < 128) ? ((128 + t) * 2 ** k) / 128 : (t * 2 ** (k + 1)) / 128;
    return ((p < 0) != (q < 0)) ? -pr : pr;
  endfunction

  initial begin
    logic signed [7:0] r [6];
    int sa, se, ma, me;
    set_ops(1'b0, 0, 0, 0, 0, 0, 0);
    #1;
    expect_y("reset", 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 3, 3, 0, 0, 0, 0);
    expect_y("three_sq", 8, 9, 1'b1);
    drive(1'b1, 5, 6, 0, 0, 0, 0);
    expect_y("five_six", 28, 30, 1'b1);
    drive(1'b1, -5, 6, 0, 0, 0, 0);
    expect_y("neg_five_six", -28, -30, 1'b1);
    drive(1'b1, -128, -128, 127, 127, -128, 127);
    expect_y("extremes", 16256, 16257, 1'b1);
    drive(1'b1, 0, -77, 64, -2, 0, 0);
    expect_y("zero_pow2", -128, -128, 1'b1);
    drive(1'b0, 1, 1, 1, 1, 1, 1);
    expect_y("bubble", -128, -128, 1'b0);
    drive(1'b1, 7, 7, 0, 0, 0, 0);
    expect_y("after_bubble", 48, 49, 1'b1);
    @(negedge clk);
    set_ops(1'b1, 5, 6, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    expect_y("async_rst", 0, 0, 1'b0);
    @(posedge clk);
    #1;
    expect_y("rst_held", 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_y("rst_release", 28, 30, 1'b1);
    drive(1'b1, -3, 5, 2, 2, 0, 0);
    expect_y("resume", -10, -11, 1'b1);
    for (int n = 0; n < 1500; n++) begin
      for (int j = 0; j < 6; j++) r[j] = (n % 2 == 1 && j > 1) ? 8'sd0 : 8'($urandom);
      drive(1'b1, r[0], r[1], r[2], r[3], r[4], r[5]);
      sa = mitch(r[0], r[1]) + mitch(r[2], r[3]) + mitch(r[4], r[5]);
      se = r[0] * r[1] + r[2] * r[3] + r[4] * r[5];
      chk("rand_approx", ia.y, sa);
      chk("rand_exact", ie.y, se);
      if (n % 2 == 1 && se != 0) begin
        ma = (ia.y < 0) ? -ia.y : ia.y;
        me = (ie.y < 0) ? -ie.y : ie.y;
        chk("rand_le_exact", 32'(ma <= me), 32'd1);
        chk("rand_rel_err", 32'((me - ma) * 1000 <= 112 * me), 32'd1);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
